// File: rtl/img_pkg.sv
// Shared constants and state type for the imgproc pixel server.
package img_pkg;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 8;
   localparam int IMG_DEPTH  = 2**DEF_ADDR_W;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} srv_state_t;

endpackage

// File: rtl/img_sp_ram.sv
// One-write/one-read synchronous RAM with a registered read port.
module img_sp_ram
   import img_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read-before-write: a same-cycle write to raddr returns the old word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/img_pixel_server.sv
// Memory-side pixel server for imgproc: serves source reads, captures result writes.
// state | meaning
// IDLE  | waiting for the first imgproc read or write
// RUN   | serving reads and capturing writes
// DRAIN | finish seen, in-flight reads still emerging
// DONE  | complete until reset; new traffic flags err
module img_pixel_server
   import img_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request,
   input  logic [ADDR_W-1:0] orig_addr,
   output logic [DATA_W-1:0] orig_data,
   output logic              orig_ready,
   input  logic              imgproc_ready,
   input  logic [ADDR_W-1:0] imgproc_addr,
   input  logic [DATA_W-1:0] imgproc_data,
   input  logic              finish,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic [ADDR_W-1:0] res_raddr,
   output logic [DATA_W-1:0] res_rdata,
   output logic [ADDR_W:0]   wr_count,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   srv_state_t        state;
   logic [RD_LAT-1:0] vld;
   logic [DATA_W-1:0] src_rdata;
   logic              req_ok;
   logic              wr_ok;

   assign req_ok     = request && (state == IDLE || state == RUN);
   assign wr_ok      = imgproc_ready && (state != DONE);
   assign orig_ready = vld[RD_LAT-1];

   img_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_src_ram (
      .clk(clk), .rst(rst),
      .we(load_en), .waddr(load_addr), .wdata(load_data),
      .re(req_ok), .raddr(orig_addr), .rdata(src_rdata)
   );

   img_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_res_ram (
      .clk(clk), .rst(rst),
      .we(wr_ok), .waddr(imgproc_addr), .wdata(imgproc_data),
      .re(1'b1), .raddr(res_raddr), .rdata(res_rdata)
   );

   // The source RAM read register is the first pipeline stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
      end else begin
         vld[0] <= req_ok;
         for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      end
   end

   if (RD_LAT == 1) begin : g_lat1
      assign orig_data = src_rdata;
   end else begin : g_latn
      // dat[i] travels alongside vld[i+1]; it only moves with a valid word so the output holds.
      logic [DATA_W-1:0] dat [RD_LAT-1];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int i = 0; i < RD_LAT-1; i++) dat[i] <= '0;
         end else begin
            if (vld[0]) dat[0] <= src_rdata;
            for (int i = 1; i < RD_LAT-1; i++) begin
               if (vld[i]) dat[i] <= dat[i-1];
            end
         end
      end

      assign orig_data = dat[RD_LAT-2];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         done     <= 1'b0;
         err      <= 1'b0;
         wr_count <= '0;
      end else begin
         if ((request && !req_ok) || (request && load_en) || (imgproc_ready && !wr_ok))
            err <= 1'b1;
         if (wr_ok && wr_count != CNT_MAX)
            wr_count <= wr_count + 1'b1;
         case (state)
            IDLE: begin
               if (finish)                        state <= DRAIN;
               else if (request || imgproc_ready) state <= RUN;
            end
            RUN: begin
               if (finish) state <= DRAIN;
            end
            DRAIN: begin
               if (vld == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= DONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_img_pixel_server.sv
// Self-checking bench for img_pixel_server: directed vectors plus random traffic
// compared against a transaction-level model of the source/result images.
module tb_img_pixel_server;
   import img_pkg::*;

   localparam int AW    = DEF_ADDR_W;
   localparam int DW    = DEF_DATA_W;
   localparam int LAT   = 2;
   localparam int DEPTH = IMG_DEPTH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          request = 1'b0;
   logic [AW-1:0] orig_addr = '0;
   logic [DW-1:0] orig_data;
   logic          orig_ready;
   logic          imgproc_ready = 1'b0;
   logic [AW-1:0] imgproc_addr = '0;
   logic [DW-1:0] imgproc_data = '0;
   logic          finish = 1'b0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [DW-1:0] load_data = '0;
   logic [AW-1:0] res_raddr = '0;
   logic [DW-1:0] res_rdata;
   logic [AW:0]   wr_count;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   img_pixel_server #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .request(request), .orig_addr(orig_addr), .orig_data(orig_data), .orig_ready(orig_ready),
      .imgproc_ready(imgproc_ready), .imgproc_addr(imgproc_addr), .imgproc_data(imgproc_data),
      .finish(finish),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .res_raddr(res_raddr), .res_rdata(res_rdata),
      .wr_count(wr_count), .done(done), .err(err)
   );

   // Reference model: image arrays, a queue of promised read responses, and a phase number
   // (0 idle, 1 running, 2 finishing, 3 finished).
   typedef struct { int due; logic [DW-1:0] data; } rsp_t;
   typedef struct { bit req; logic [AW-1:0] addr; bit rdy; logic [DW-1:0] data; } vec_t;

   rsp_t          rsp_q[$];
   logic [DW-1:0] m_src [DEPTH];
   logic [DW-1:0] m_res [DEPTH];
   bit            m_res_ok [DEPTH];
   int            phase, cyc, last_due, exp_cnt;
   bit            exp_err, exp_res_ok;
   logic [DW-1:0] exp_orig, exp_res;
   int            n_checks, n_fail;
   vec_t          vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_inputs();
      request = 1'b0; imgproc_ready = 1'b0; finish = 1'b0; load_en = 1'b0;
   endtask

   // Apply the current inputs for one clock, advance the model, compare every output.
   task automatic step();
      bit pend, acc, rdy;
      pend = (last_due >= cyc - 1);
      acc  = request && (phase < 2);
      if (request && (phase >= 2 || load_en)) exp_err = 1'b1;
      if (acc) begin
         rsp_q.push_back('{due: cyc + LAT - 1, data: m_src[orig_addr]});
         last_due = cyc + LAT - 1;
      end
      exp_res_ok = m_res_ok[res_raddr];
      exp_res    = m_res[res_raddr];
      if (imgproc_ready) begin
         if (phase == 3) exp_err = 1'b1;
         else begin
            m_res[imgproc_addr]    = imgproc_data;
            m_res_ok[imgproc_addr] = 1'b1;
            if (exp_cnt < DEPTH) exp_cnt++;
         end
      end
      if (load_en) m_src[load_addr] = load_data;
      case (phase)
         0: if (finish) phase = 2; else if (request || imgproc_ready) phase = 1;
         1: if (finish) phase = 2;
         2: if (!pend) phase = 3;
         default: ;
      endcase
      @(posedge clk);
      #1;
      rdy = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         rdy      = 1'b1;
         exp_orig = rsp_q[0].data;
         void'(rsp_q.pop_front());
      end
      chk("orig_ready", 32'(orig_ready), 32'(rdy));
      chk("orig_data", 32'(orig_data), 32'(exp_orig));
      if (exp_res_ok) chk("res_rdata", 32'(res_rdata), 32'(exp_res));
      chk("wr_count", 32'(wr_count), 32'(exp_cnt));
      chk("done", 32'(done), 32'(phase == 3));
      chk("err", 32'(err), 32'(exp_err));
      cyc++;
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b0;
      #1;
      chk("rst_orig_ready", 32'(orig_ready), 32'(0));
      chk("rst_orig_data", 32'(orig_data), 32'(0));
      chk("rst_res_rdata", 32'(res_rdata), 32'(0));
      chk("rst_wr_count", 32'(wr_count), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      repeat (ncyc) @(posedge clk);
      rsp_q.delete();
      phase = 0; last_due = -100; exp_cnt = 0; exp_err = 1'b0;
      exp_orig = '0; exp_res_ok = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Loads and reads share a window away from the directed addresses 5, 6 and 9.
   task automatic rand_inputs(input bit fin_ok);
      request       = ($urandom_range(0, 99) < 50);
      orig_addr     = AW'($urandom_range(32, 95));
      load_en       = ($urandom_range(0, 99) < 15);
      load_addr     = AW'($urandom_range(32, 95));
      load_data     = DW'($urandom);
      imgproc_ready = ($urandom_range(0, 99) < 40);
      imgproc_addr  = AW'($urandom_range(0, 31));
      imgproc_data  = DW'($urandom);
      res_raddr     = AW'($urandom_range(0, 31));
      finish        = fin_ok && ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; last_due = -100;
      phase = 0; exp_cnt = 0; exp_err = 1'b0; exp_orig = '0;
      @(negedge clk);
      do_reset(2);

      for (int k = 0; k < DEPTH; k++) begin
         load_en = 1'b1; load_addr = AW'(k); load_data = DW'(k);
         step();
      end
      load_en = 1'b0;

      // Back-to-back reads of 5,6,7: pulses two cycles after each request, in order.
      vecs[0] = '{1'b1, AW'(5), 1'b0, 8'h00};
      vecs[1] = '{1'b1, AW'(6), 1'b1, 8'h05};
      vecs[2] = '{1'b1, AW'(7), 1'b1, 8'h06};
      vecs[3] = '{1'b0, AW'(0), 1'b1, 8'h07};
      vecs[4] = '{1'b0, AW'(0), 1'b0, 8'h07};
      for (int i = 0; i < 5; i++) begin
         request = vecs[i].req; orig_addr = vecs[i].addr;
         step();
         chk("tbl_ready", 32'(orig_ready), 32'(vecs[i].rdy));
         chk("tbl_data", 32'(orig_data), 32'(vecs[i].data));
      end

      imgproc_ready = 1'b1; imgproc_addr = AW'(16'h3FFF); imgproc_data = 8'hA5; step();
      imgproc_addr = '0; imgproc_data = 8'h5A; step();
      imgproc_ready = 1'b0; res_raddr = AW'(16'h3FFF); step();
      chk("res_capture", 32'(res_rdata), 32'(8'hA5));
      chk("res_wr_count", 32'(wr_count), 32'(2));
      imgproc_ready = 1'b1; imgproc_addr = '0; imgproc_data = 8'h77; res_raddr = '0; step();
      chk("res_old_on_collide", 32'(res_rdata), 32'(8'h5A));
      imgproc_ready = 1'b0; step();
      chk("res_new_after", 32'(res_rdata), 32'(8'h77));

      for (int i = 0; i < 3000; i++) begin
         rand_inputs(1'b0);
         step();
      end

      clear_inputs();
      do_reset(2);
      imgproc_ready = 1'b1; imgproc_addr = '0; imgproc_data = 8'h3C; step();
      for (int k = 0; k < DEPTH; k++) begin
         imgproc_addr = AW'(k); imgproc_data = DW'(k + 3);
         step();
      end
      chk("sat_count", 32'(wr_count), 32'(DEPTH));
      chk("sat_err", 32'(err), 32'(0));
      imgproc_addr = AW'(1); step();
      chk("sat_hold", 32'(wr_count), 32'(DEPTH));
      imgproc_ready = 1'b0;

      load_en = 1'b1; load_addr = AW'(9); load_data = 8'h11; step();
      load_data = 8'h22; request = 1'b1; orig_addr = AW'(9); step();
      load_en = 1'b0; step();
      chk("coll_ready", 32'(orig_ready), 32'(1));
      chk("coll_old_data", 32'(orig_data), 32'(8'h11));
      chk("coll_err", 32'(err), 32'(1));
      request = 1'b0; step();
      chk("coll_new_data", 32'(orig_data), 32'(8'h22));

      request = 1'b1; orig_addr = AW'(5); step();
      clear_inputs();
      do_reset(2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_ready", 32'(orig_ready), 32'(0));
      end
      request = 1'b1; orig_addr = AW'(5); step();
      request = 1'b0; step();
      chk("rst_ram_kept_ready", 32'(orig_ready), 32'(1));
      chk("rst_ram_kept_data", 32'(orig_data), 32'(8'h05));

      clear_inputs();
      do_reset(1);
      request = 1'b1; orig_addr = AW'(6); step();
      request = 1'b0; finish = 1'b1; step();
      chk("drain_pulse", 32'(orig_ready), 32'(1));
      chk("drain_data", 32'(orig_data), 32'(8'h06));
      finish = 1'b0;
      for (int t = 0; t < 8 && !done; t++) step();
      chk("drain_done", 32'(done), 32'(1));
      request = 1'b1; orig_addr = AW'(6); imgproc_ready = 1'b1; imgproc_addr = AW'(3); step();
      clear_inputs(); step();
      chk("done_no_ready", 32'(orig_ready), 32'(0));
      chk("done_err", 32'(err), 32'(1));
      chk("done_write_dropped", 32'(wr_count), 32'(0));

      do_reset(1);
      finish = 1'b1; step();
      chk("idle_fin_not_done", 32'(done), 32'(0));
      finish = 1'b0; step();
      chk("idle_fin_done", 32'(done), 32'(1));

      for (int r = 0; r < 4; r++) begin
         clear_inputs();
         do_reset(1);
         for (int i = 0; i < 600; i++) begin
            rand_inputs(1'b1);
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/img_pixel_server.md
Name: img_pixel_server

Overview:
- Memory-side counterpart of the imgproc block's pixel interfaces.
- Serves imgproc's pixel read requests (request/orig_addr -> orig_data/orig_ready) from an internal source image RAM.
- Captures imgproc's processed-pixel writes (imgproc_ready/addr/data) into an internal result RAM.
- Host-side ports preload the source image and read back the result. Tracks write count and the finish handshake.

Parameters:
- ADDR_W, 14, pixel address width; image depth is 2**ADDR_W.
- DATA_W, 8, pixel width.
- RD_LAT, 2, request-to-orig_ready latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- request  in  1  imgproc read request, one pixel per cycle when high.
- orig_addr  in  ADDR_W  read address, valid with request.
- orig_data  out  DATA_W  returned pixel.
- orig_ready  out  1  orig_data valid, one-cycle pulse per request.
- imgproc_ready  in  1  result write strobe.
- imgproc_addr  in  ADDR_W  result write address.
- imgproc_data  in  DATA_W  result write data.
- finish  in  1  imgproc completion indication.
- load_en  in  1  host preload strobe into the source RAM.
- load_addr  in  ADDR_W  preload address.
- load_data  in  DATA_W  preload data.
- res_raddr  in  ADDR_W  host result readback address.
- res_rdata  out  DATA_W  result RAM data for res_raddr, one cycle later.
- wr_count  out  ADDR_W+1  number of accepted result writes, saturating.
- done  out  1  finish seen and read pipeline drained.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst low, asynchronous):
  - State: FSM goes to IDLE; read pipeline valid bits clear.
  - Outputs: orig_ready=0, orig_data=0, res_rdata=0, wr_count=0, done=0, err=0.
  - RAM contents are not reset.
  - Reset mid-operation discards all in-flight reads; no orig_ready pulse follows the reset release.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE->RUN on the first cycle with request=1 or imgproc_ready=1.
  - RUN->DRAIN on finish=1.
  - DRAIN->DONE when the read pipeline is empty. If it is already empty, DRAIN lasts exactly 1 cycle.
  - DONE is terminal until reset.
  - done=1 only in DONE.
- Read path:
  - Pipeline of RD_LAT stages (valid bit + address/data).
  - request=1 at edge N produces orig_ready=1 with orig_data=src[orig_addr] at edge N+RD_LAT.
  - Back-to-back requests give back-to-back pulses, in order. No stalls, no backpressure.
  - orig_data holds its last value when orig_ready=0.
- Requests in DRAIN or DONE: ignored (no orig_ready), err set.
- Result write path:
  - imgproc_ready=1 writes imgproc_data to res[imgproc_addr] at that edge.
  - wr_count increments and saturates at 2**ADDR_W. Rewrites to the same address each count.
  - Writes in DONE are dropped, wr_count unchanged, err set. Writes in DRAIN are accepted.
- Preload:
  - load_en writes src[load_addr]=load_data in any state.
  - If load_en and request occur in the same cycle, the read is served from the pre-write contents and err is set.
  - A read issued the cycle after a load to the same address returns the new data.
- Readback: res_rdata = res[res_raddr] registered, 1-cycle latency, available in all states. A same-cycle write to the same address returns the old data.
- finish asserted while in IDLE: go directly to DRAIN.
- err is sticky until reset.

Decomposition:
- Shared package img_pkg:
  - ADDR_W/DATA_W defaults and IMG_DEPTH constant.
  - Enum srv_state_t {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module, img_sp_ram: a 1-write/1-read synchronous RAM, instantiated twice (source, result). Keeps it mappable to macros.
- The read pipeline and FSM stay in the top module.

Test Plan:
- Latency/ordering:
  - Stimulus: preload src[k]=k[7:0] for k=0..16383, RD_LAT=2, requests to addresses 5,6,7 on consecutive cycles.
  - Response: orig_ready high exactly 2,3,4 cycles after the first request, data 0x05,0x06,0x07.
- Result capture:
  - Stimulus: write res[0x3FFF]=0xA5, res[0]=0x5A, then res_raddr=0x3FFF.
  - Response: res_rdata=0xA5 one cycle later; wr_count=2.
- Saturation:
  - Stimulus: 16385 writes (address 0 twice).
  - Response: wr_count=16384, err=0.
- Finish/drain:
  - Stimulus: request at cycle N, finish at N+1.
  - Response: orig_ready still pulses at N+2; done=1 once the pipeline is empty. A request after done gives no orig_ready and sets err=1.
- Collision:
  - Stimulus: src[9]=0x11; same cycle load_en to address 9 with 0x22 and request to address 9.
  - Response: returns 0x11, err=1. The next request to address 9 returns 0x22.
- Reset mid-read:
  - Stimulus: request at N, rst low at N+1 for 2 cycles.
  - Response: no orig_ready pulse; all outputs 0; RAM contents preserved (re-read of address 5 returns 0x05).
